scoreboarded_register_file: RTL
===============================

SCOREBOARDED_REGISTER_FILE -- requirements
Module: scoreboarded_register_file

Interface
REQ-001 Parameter DataWidth, default 32: width of each register, in bits.
REQ-002 Parameter RegisterCount, default 32: number of architectural registers. Legal values are powers of two, at least 2.
REQ-003 Parameter ReadPortCount, default 2: number of independent read ports.
REQ-004 Parameter WritePortCount, default 2: number of independent write ports.
REQ-005 The block SHALL use one clock, clk_i, input, 1 bit, with all state updating on its rising edge.
REQ-006 Reset SHALL be rst_ni, input, 1 bit, asynchronous and active-low.
REQ-007 read_address_i[ReadPortCount], input, $clog2(RegisterCount) bits each: read-port register index.
REQ-008 read_data_o[ReadPortCount], output, DataWidth bits each: read-port data.
REQ-009 read_busy_o[ReadPortCount], output, 1 bit each: the addressed register has a pending write.
REQ-010 reserve_valid_i, input, 1 bit: request to mark reserve_address_i busy.
REQ-011 reserve_address_i, input, $clog2(RegisterCount) bits: register to reserve.
REQ-012 reserve_ready_o, output, 1 bit: the reservation is accepted this cycle.
REQ-013 write_enable_i[WritePortCount], input, 1 bit each: write-port enable.
REQ-014 write_address_i[WritePortCount], input, $clog2(RegisterCount) bits each: write-port register index.
REQ-015 write_data_i[WritePortCount], input, DataWidth bits each: write-port data.
REQ-016 busy_o, output, RegisterCount bits: the complete scoreboard vector.

Function
REQ-017 Register 0 SHALL read as 0, SHALL ignore writes and reservations, and SHALL never be busy.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from address to read_data_o and read_busy_o.
REQ-019 A write SHALL update the register on the next rising edge when its enable is high and its address is nonzero.
REQ-020 When multiple write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-021 reserve_ready_o SHALL equal NOT busy[reserve_address_i] OR reserve_address_i == 0. This is combinational; a write-after-write stall occurs while the target is busy.
REQ-022 A reservation is a handshake in which reserve_valid_i and reserve_ready_o are both high. It SHALL set busy[reserve_address_i] on the next edge, unless the address is 0.
REQ-023 A valid write to address A SHALL clear busy[A] on the next edge.
REQ-024 When a reservation and a write target the same address in the same cycle, data SHALL be written and busy SHALL end the cycle set, because the reservation takes precedence.
REQ-025 A write to a non-busy register SHALL still update the data and SHALL leave busy at 0.
REQ-026 A reservation to register 0 SHALL be accepted, with reserve_ready_o=1, and SHALL have no effect.

Reset
REQ-027 Asserting rst_ni low SHALL immediately clear all registers to 0 and all busy bits to 0, regardless of the clock.
REQ-028 While in reset, reserve_ready_o SHALL be 1, and read_data_o and read_busy_o SHALL be 0.
REQ-029 Writes or reservations presented during reset SHALL be discarded.
REQ-030 Operation SHALL resume on the first rising edge after rst_ni goes high.

Configuration
REQ-031 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 When REGFILE_BYPASS_EN is defined, a read port whose address matches a same-cycle valid write SHALL behave as follows:
- it SHALL return that write's data, applying the highest-index rule;
- read_busy_o SHALL be 0 for that port unless a same-cycle reservation targets that address.
REQ-033 When REGFILE_BYPASS_EN is undefined, reads SHALL return only the stored value and the registered busy bit, and the write becomes visible the following cycle.

Verification
REQ-034 Reset check: hold rst_ni low mid-operation with x5 busy -> busy_o=0, read of x5 = 0, and reserve_ready_o=1 asynchronously.
REQ-035 Reserve and write: reserve x3, then write x3=0xDEADBEEF two cycles later, with the following responses:
- read_busy_o=1 for the cycles in between;
- busy cleared after the write edge;
- read returns 0xDEADBEEF.
REQ-036 Write-after-write stall: with x7 busy, reserve_valid_i=1 to x7 -> reserve_ready_o=0 and no state change; write x7 -> reserve_ready_o=1 on the next cycle.
REQ-037 Port conflict: port0 writes x4=0x1 and port1 writes x4=0x2 in the same cycle -> x4 reads 0x2.
REQ-038 Zero register: write x0=0xFFFFFFFF and reserve x0 -> x0 reads 0, busy_o[0]=0, reserve_ready_o=1.
REQ-039 Bypass (both builds): write x9=0xA5 while reading x9 in the same cycle:
- with REGFILE_BYPASS_EN, the same-cycle read returns 0xA5;
- without it, the same-cycle read returns the old value and the next cycle returns 0xA5.

Source files
------------

// File: rtl/scoreboarded_register_file.sv
// Multi-ported register file with a per-register busy scoreboard for pending writes.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy status to the read ports.
module scoreboarded_register_file #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned RegisterCount  = 32,
  parameter int unsigned ReadPortCount  = 2,
  parameter int unsigned WritePortCount = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [$clog2(RegisterCount)-1:0] read_address_i  [ReadPortCount],
  output logic [DataWidth-1:0]             read_data_o     [ReadPortCount],
  output logic                             read_busy_o     [ReadPortCount],
  input  logic                             reserve_valid_i,
  input  logic [$clog2(RegisterCount)-1:0] reserve_address_i,
  output logic                             reserve_ready_o,
  input  logic                             write_enable_i  [WritePortCount],
  input  logic [$clog2(RegisterCount)-1:0] write_address_i [WritePortCount],
  input  logic [DataWidth-1:0]             write_data_i    [WritePortCount],
  output logic [RegisterCount-1:0]         busy_o
);

  logic [DataWidth-1:0]     regs_q [RegisterCount];
  logic [DataWidth-1:0]     regs_d [RegisterCount];
  logic [RegisterCount-1:0] busy_q, busy_d;
  logic                     reserve_fire;

  assign reserve_ready_o = ~busy_q[reserve_address_i] | (reserve_address_i == '0);
  assign reserve_fire    = reserve_valid_i & reserve_ready_o & (reserve_address_i != '0);
  assign busy_o          = busy_q;

  // Ascending port order makes the highest-index write win; the reservation is applied last
  // so it takes precedence over a same-cycle write clearing the busy bit.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < WritePortCount; w++) begin
      if (write_enable_i[w] && (write_address_i[w] != '0)) begin
        regs_d[write_address_i[w]] = write_data_i[w];
        busy_d[write_address_i[w]] = 1'b0;
      end
    end
    if (reserve_fire) begin
      busy_d[reserve_address_i] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegisterCount; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int r = 0; r < ReadPortCount; r++) begin
      read_data_o[r] = regs_q[read_address_i[r]];
      read_busy_o[r] = busy_q[read_address_i[r]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < WritePortCount; w++) begin
        if (write_enable_i[w] && (write_address_i[w] != '0) &&
            (write_address_i[w] == read_address_i[r])) begin
          read_data_o[r] = write_data_i[w];
          read_busy_o[r] = reserve_fire && (reserve_address_i == read_address_i[r]);
        end
      end
`endif
      // Forwarded inputs must not leak out while reset is held.
      if (!rst_ni) begin
        read_data_o[r] = '0;
        read_busy_o[r] = 1'b0;
      end
    end
  end

endmodule
